// File: rtl/pc.sv
// pc: program counter register with load enable and synchronous reset
module pc #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic [WIDTH-1:0] PCin,
  output logic [WIDTH-1:0] updatedPC
);
  logic [WIDTH-1:0] pc_q;
  // reset wins over a pending load; a deasserted PCWrite freezes fetch
  always_ff @(posedge clk)
    pc_q <= reset ? RESET_VECTOR : (PCWrite ? PCin : pc_q);
  assign updatedPC = pc_q;
endmodule

// File: tb/tb_pc.sv
// tb_pc: directed self-checking bench for the program counter register
module tb_pc;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic [15:0] PCin;
  logic [15:0] u0;
  logic [15:0] u1;
  int checks = 0;
  int errors = 0;

  pc dut (.clk(clk), .reset(reset), .PCWrite(PCWrite), .PCin(PCin), .updatedPC(u0));
  pc #(.WIDTH(16), .RESET_VECTOR(16'h0100)) dut_rv (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCin(PCin), .updatedPC(u1));

  always #5 clk = ~clk;

  // an unknown load enable outside reset is illegal stimulus
  always @(posedge clk)
    if (!reset && $isunknown(PCWrite)) begin
      errors++;
      $display("FAIL pcwrite_known: PCWrite=%b while reset=0", PCWrite);
    end

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; PCWrite = 1'b1; PCin = 16'hAFAA;
    for (int i = 0; i < 3; i++) begin
      edge_settle();
      checks++;
      if (u0 !== 16'h0000) begin errors++; $display("FAIL reset_prio[%0d]: got %h want 0000", i, u0); end
      checks++;
      if (u1 !== 16'h0100) begin errors++; $display("FAIL reset_vector[%0d]: got %h want 0100", i, u1); end
    end
    reset = 1'b0; PCWrite = 1'b0; PCin = 16'h5555;
    edge_settle();
    checks++;
    if (u0 !== 16'h0000) begin errors++; $display("FAIL release_hold: got %h want 0000", u0); end
    checks++;
    if (u1 !== 16'h0100) begin errors++; $display("FAIL release_hold_rv: got %h want 0100", u1); end
  endtask

  task automatic test_load();
    PCWrite = 1'b1; PCin = 16'hAFAA;
    edge_settle();
    checks++;
    if (u0 !== 16'hAFAA) begin errors++; $display("FAIL load: got %h want AFAA", u0); end
    PCin = 16'hFFFF;
    #2;
    checks++;
    if (u0 !== 16'hAFAA) begin errors++; $display("FAIL load_midcycle: got %h want AFAA", u0); end
    edge_settle();
    checks++;
    if (u0 !== 16'hFFFF) begin errors++; $display("FAIL load_next: got %h want FFFF", u0); end
  endtask

  task automatic test_stall();
    PCWrite = 1'b0; PCin = 16'h1110;
    edge_settle();
    checks++;
    if (u0 !== 16'hFFFF) begin errors++; $display("FAIL stall0: got %h want FFFF", u0); end
    PCin = 16'h4646;
    edge_settle();
    checks++;
    if (u0 !== 16'hFFFF) begin errors++; $display("FAIL stall1: got %h want FFFF", u0); end
  endtask

  task automatic test_reset_mid();
    PCWrite = 1'b1; PCin = 16'h1234;
    edge_settle();
    checks++;
    if (u0 !== 16'h1234) begin errors++; $display("FAIL mid_load: got %h want 1234", u0); end
    PCin = 16'h7777;
    #2 reset = 1'b1;
    #2;
    checks++;
    if (u0 !== 16'h1234) begin errors++; $display("FAIL mid_no_async: got %h want 1234", u0); end
    edge_settle();
    checks++;
    if (u0 !== 16'h0000) begin errors++; $display("FAIL mid_reset: got %h want 0000", u0); end
    reset = 1'b0; PCWrite = 1'b1; PCin = 16'h0001;
    edge_settle();
    checks++;
    if (u0 !== 16'h0001) begin errors++; $display("FAIL mid_release_load: got %h want 0001", u0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3] = '{16'hFFFF, 16'h0000, 16'h8000};
    logic [15:0] prev;
    PCWrite = 1'b1;
    prev = u0;
    for (int i = 0; i < 3; i++) begin
      PCin = vals[i];
      #2;
      checks++;
      if (u0 !== prev) begin errors++; $display("FAIL b2b_pre[%0d]: got %h want %h", i, u0, prev); end
      edge_settle();
      checks++;
      if (u0 !== vals[i]) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", i, u0, vals[i]); end
      prev = vals[i];
    end
    checks++;
    if (u1 !== 16'h8000) begin errors++; $display("FAIL b2b_rv: got %h want 8000", u1); end
  endtask

  initial begin
    reset = 1'b1; PCWrite = 1'b1; PCin = 16'hAFAA;
    test_reset();
    test_load();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
